// File: rtl/cdc_bus_tx_ctrl_pkg.sv
// Shared types, default parameters and width helpers for the CDC bus transmit controller.
package cdc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HOLD  = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_BUS_WIDTH   = 8;
  localparam int DEF_HOLD_CYCLES = 4;
  localparam int DEF_GAP_CYCLES  = 4;
  localparam int DEF_SYNC_STAGES = 2;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counter must hold the larger of the two phase lengths.
  function automatic int cnt_width(input int hold_c, input int gap_c);
    return $clog2(((hold_c > gap_c) ? hold_c : gap_c) + 1);
  endfunction

endpackage

// File: rtl/cdc_bus_tx_ctrl_if.sv
// Requester/transmit bundle between the requesters, the controller and the destination synchronizer.
// ack_async exists only when CDC_TX_ACK_EN is defined.
interface cdc_bus_tx_ctrl_if #(
  parameter int NUM_REQ   = cdc_ctrl_pkg::DEF_NUM_REQ,
  parameter int BUS_WIDTH = cdc_ctrl_pkg::DEF_BUS_WIDTH
);
  localparam int IW = cdc_ctrl_pkg::idx_width(NUM_REQ);

  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*BUS_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]           grant;
  logic [IW-1:0]                owner;
  logic                         busy;
  logic                         done;
  logic [BUS_WIDTH-1:0]         tx_bus;
  logic                         tx_enable;
`ifdef CDC_TX_ACK_EN
  logic                         ack_async;
`endif

  modport master (
`ifdef CDC_TX_ACK_EN
    input  ack_async,
`endif
    input  req, req_data,
    output grant, owner, busy, done, tx_bus, tx_enable
  );

  modport slave (
`ifdef CDC_TX_ACK_EN
    output ack_async,
`endif
    output req, req_data,
    input  grant, owner, busy, done, tx_bus, tx_enable
  );

endinterface

// File: rtl/cdc_bus_tx_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first set request searching upward from i_ptr with wrap.
module rr_arbiter
  import cdc_ctrl_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [idx_width(NUM_REQ)-1:0] i_ptr,
  input  logic                          i_en,
  output logic [NUM_REQ-1:0]            o_gnt,
  output logic [idx_width(NUM_REQ)-1:0] o_idx
);
  localparam int W = idx_width(NUM_REQ);

  logic [W:0] w_cand;
  logic       w_found;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = {1'b0, i_ptr} + (W+1)'(k);
      if (w_cand >= (W+1)'(NUM_REQ)) w_cand = w_cand - (W+1)'(NUM_REQ);
      if (i_en && !w_found && i_req[w_cand[W-1:0]]) begin
        w_found = 1'b1;
        o_gnt   = NUM_REQ'(1) << w_cand[W-1:0];
        o_idx   = w_cand[W-1:0];
      end
    end
  end

endmodule

// File: rtl/cdc_bus_tx_ctrl.sv
// Round-robin owner of one CDC bus channel: latches the winner's word and sequences tx_enable.
// Defining CDC_TX_ACK_EN stretches HOLD/GAP until a synchronized destination ack completes a four-phase handshake.
module cdc_bus_tx_ctrl
  import cdc_ctrl_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int BUS_WIDTH   = DEF_BUS_WIDTH,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
`ifdef CDC_TX_ACK_EN
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
`endif
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
  input logic               clk,
  input logic               rst,
  cdc_bus_tx_ctrl_if.master bus
);
  localparam int IW = idx_width(NUM_REQ);
  localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

  state_t               r_state;
  logic [IW-1:0]        r_ptr;
  logic [IW-1:0]        r_owner;
  logic [NUM_REQ-1:0]   r_grant;
  logic                 r_busy;
  logic                 r_done;
  logic [BUS_WIDTH-1:0] r_tx_bus;
  logic                 r_tx_enable;
  logic [CW-1:0]        r_cnt;

  logic [NUM_REQ-1:0]   w_gnt;
  logic [IW-1:0]        w_idx;
  logic                 w_cnt_last;
  logic                 w_hold_done;
  logic                 w_gap_done;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req (bus.req),
    .i_ptr (r_ptr),
    .i_en  (r_state == IDLE),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  assign w_cnt_last = (r_cnt == CW'(1));

`ifdef CDC_TX_ACK_EN
  logic [SYNC_STAGES-1:0] r_ack_sync;
  logic                   w_ack_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_ack_sync <= '0;
    else      r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], bus.ack_async};
  end

  assign w_ack_s     = r_ack_sync[SYNC_STAGES-1];
  assign w_hold_done = w_cnt_last && w_ack_s;
  assign w_gap_done  = w_cnt_last && !w_ack_s;
`else
  assign w_hold_done = w_cnt_last;
  assign w_gap_done  = w_cnt_last;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_grant     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_tx_bus    <= '0;
      r_tx_enable <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_grant <= '0;
      r_done  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (|w_gnt) begin
            r_state  <= SETUP;
            r_tx_bus <= bus.req_data[w_idx*BUS_WIDTH +: BUS_WIDTH];
            r_owner  <= w_idx;
            r_ptr    <= (w_idx == LAST_IDX) ? '0 : w_idx + 1'b1;
            r_grant  <= w_gnt;
            r_busy   <= 1'b1;
          end
        end
        SETUP: begin
          r_state     <= HOLD;
          r_tx_enable <= 1'b1;
          r_cnt       <= HOLD_LD;
        end
        // Counter parks at 1 while an ack stretch is pending.
        HOLD: begin
          if (w_hold_done) begin
            r_state     <= GAP;
            r_tx_enable <= 1'b0;
            r_cnt       <= GAP_LD;
          end else if (!w_cnt_last) begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        GAP: begin
          if (w_gap_done) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_cnt   <= '0;
          end else if (!w_cnt_last) begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.grant     = r_grant;
  assign bus.owner     = r_owner;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.tx_bus    = r_tx_bus;
  assign bus.tx_enable = r_tx_enable;

endmodule

// File: tb/tb_cdc_bus_tx_ctrl.sv
// Directed plus randomized bench for cdc_bus_tx_ctrl against a transaction-level rotation model.
module tb_cdc_bus_tx_ctrl;
  import cdc_ctrl_pkg::*;

  localparam int N  = 4;
  localparam int BW = 8;
  localparam int H  = 4;
  localparam int G  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: rotation start point, last latched word and owner.
  int            m_ptr   = 0;
  int            m_owner = 0;
  logic [BW-1:0] m_txbus = '0;

  cdc_bus_tx_ctrl_if #(.NUM_REQ(N), .BUS_WIDTH(BW)) bus ();

  cdc_bus_tx_ctrl #(
    .NUM_REQ    (N),
    .BUS_WIDTH  (BW),
    .HOLD_CYCLES(H),
    .GAP_CYCLES (G)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

`ifdef CDC_TX_ACK_EN
  initial bus.ack_async = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++)
      if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic scramble();
    for (int i = 0; i < N; i++) bus.req_data[i*BW +: BW] = BW'($urandom);
  endtask

  task automatic idle(input int n);
    bus.req = '0;
    for (int i = 0; i < n; i++) begin
      scramble();
      @(negedge clk);
      chk("idle_grant", 32'(bus.grant), 32'd0);
      chk("idle_busy",  32'(bus.busy), 32'd0);
      chk("idle_done",  32'(bus.done), 32'd0);
      chk("idle_en",    32'(bus.tx_enable), 32'd0);
      chk("idle_txbus", 32'(bus.tx_bus), 32'(m_txbus));
      chk("idle_owner", 32'(bus.owner), 32'(m_owner));
    end
  endtask

  // Starts at a negedge where the DUT is idle; ends at the negedge of the done cycle.
  task automatic xfer(input logic [N-1:0] mask, input bit drop,
                      input bit use_fd, input logic [BW-1:0] fd);
    int            w;
    logic [BW-1:0] d;
    bus.req = mask;
    scramble();
    w = pick(mask, m_ptr);
    if (use_fd) bus.req_data[w*BW +: BW] = fd;
    d       = bus.req_data[w*BW +: BW];
    m_ptr   = (w + 1) % N;
    m_txbus = d;
    m_owner = w;
    @(posedge clk);
    @(negedge clk);
    chk("setup_grant", 32'(bus.grant), 32'(1) << w);
    chk("setup_busy",  32'(bus.busy), 32'd1);
    chk("setup_owner", 32'(bus.owner), 32'(w));
    chk("setup_txbus", 32'(bus.tx_bus), 32'(d));
    chk("setup_en",    32'(bus.tx_enable), 32'd0);
    if (drop) bus.req[w] = 1'b0;
    for (int h = 0; h < H; h++) begin
      scramble();
      @(negedge clk);
      chk("hold_en",    32'(bus.tx_enable), 32'd1);
      chk("hold_grant", 32'(bus.grant), 32'd0);
      chk("hold_txbus", 32'(bus.tx_bus), 32'(d));
      chk("hold_done",  32'(bus.done), 32'd0);
    end
    for (int g = 0; g < G; g++) begin
      scramble();
      @(negedge clk);
      chk("gap_en",    32'(bus.tx_enable), 32'd0);
      chk("gap_busy",  32'(bus.busy), 32'd1);
      chk("gap_done",  32'(bus.done), 32'd0);
      chk("gap_txbus", 32'(bus.tx_bus), 32'(d));
    end
    @(negedge clk);
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("done_busy",  32'(bus.busy), 32'd0);
    chk("done_en",    32'(bus.tx_enable), 32'd0);
    chk("done_owner", 32'(bus.owner), 32'(w));
    chk("done_txbus", 32'(bus.tx_bus), 32'(d));
  endtask

  initial begin
    logic [N-1:0] mask;
    bus.req      = '1;
    bus.req_data = '0;
    rst          = 1'b0;

    // Reset held with every requester active.
    repeat (3) begin
      scramble();
      @(negedge clk);
      chk("rst_grant", 32'(bus.grant), 32'd0);
      chk("rst_owner", 32'(bus.owner), 32'd0);
      chk("rst_busy",  32'(bus.busy), 32'd0);
      chk("rst_done",  32'(bus.done), 32'd0);
      chk("rst_txbus", 32'(bus.tx_bus), 32'd0);
      chk("rst_en",    32'(bus.tx_enable), 32'd0);
    end
    rst = 1'b1;
    xfer(4'b1111, 1'b0, 1'b0, '0);
    idle(3);

    // Single requester with a fixed word.
    xfer(4'b0100, 1'b0, 1'b1, 8'hA5);
    idle(2);

    // Held multi-request: strict rotation, back-to-back.
    for (int i = 0; i < 6; i++) xfer(4'b1011, 1'b0, 1'b0, '0);

    // Single requester re-served every transfer.
    for (int i = 0; i < 3; i++) xfer(4'b0100, 1'b0, 1'b0, '0);

    // Late drop after grant.
    xfer(4'b0010, 1'b1, 1'b0, '0);
    idle(4);

    // Reset during the second HOLD cycle.
    bus.req = 4'b0010;
    scramble();
    @(posedge clk);
    @(negedge clk);
    chk("abort_grant", 32'(bus.grant), 32'b0010);
    bus.req = '0;
    @(negedge clk);
    chk("abort_en_h1", 32'(bus.tx_enable), 32'd1);
    @(negedge clk);
    chk("abort_en_h2", 32'(bus.tx_enable), 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_en",    32'(bus.tx_enable), 32'd0);
    chk("abort_busy",  32'(bus.busy), 32'd0);
    chk("abort_txbus", 32'(bus.tx_bus), 32'd0);
    chk("abort_owner", 32'(bus.owner), 32'd0);
    @(negedge clk);
    rst     = 1'b1;
    m_ptr   = 0;
    m_owner = 0;
    m_txbus = '0;
    idle(2);
    xfer(4'b1001, 1'b0, 1'b0, '0);

    // Randomized masks, drops and idle gaps.
    for (int i = 0; i < 24; i++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      xfer(mask, 1'($urandom_range(0, 1)), 1'b0, '0);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cdc_bus_tx_ctrl.md
# cdc_bus_tx_ctrl

Source-domain controller that shares a single clock-domain-crossing bus channel between several requesters. It arbitrates round-robin and latches the winner's word onto a stable transmit bus. It then sequences the level-type enable so that the destination-side multi-flop bus synchronizer (pulse generator plus hold mux) sees exactly one clean rising edge per word. The block sits in the sending clock domain, directly ahead of that synchronizer.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- BUS_WIDTH, 8: data word width
- HOLD_CYCLES, 4: cycles tx_enable stays high; ≥1; must cover destination sync depth plus clock ratio
- GAP_CYCLES, 4: cycles tx_enable stays low before the next transfer; ≥1
- SYNC_STAGES, 2: flops on the returning ack (ACK mode only); ≥2
- clk  in  1  source-domain clock
- rst  in  1  reset, asynchronous, active-low
- req  in  NUM_REQ  per-requester transfer request, level
- req_data  in  NUM_REQ*BUS_WIDTH  requester i word at bits [i*BUS_WIDTH +: BUS_WIDTH]
- grant  out  NUM_REQ  one-hot, one-cycle pulse: word accepted
- owner  out  clog2(NUM_REQ)  index of the current/last granted requester
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse: transfer complete
- tx_bus  out  BUS_WIDTH  word to the synchronizer's unsynchronized bus input; stable from SETUP through GAP
- tx_enable  out  1  to the synchronizer's bus-enable input
- ack_async  in  1  destination acknowledge level; present only with CDC_TX_ACK_EN

## Operation
- FSM states: IDLE → SETUP → HOLD → GAP → IDLE.
- IDLE:
  - req is sampled only in IDLE.
  - If any bit is set, the arbiter picks the first set bit, searching upward from rr_ptr with wrap.
  - On that edge: tx_bus ← winner's word, owner ← index, rr_ptr ← (index+1) mod NUM_REQ, state → SETUP.
- SETUP: exactly one cycle. grant[owner]=1 and tx_enable=0, so data is settled before the enable edge.
- HOLD: tx_enable=1 for HOLD_CYCLES cycles (fixed mode).
- GAP: tx_enable=0 for GAP_CYCLES cycles. On exit, state → IDLE and done=1 in the first IDLE cycle.
- A new request may be accepted on the same edge that done is high.
- tx_bus is updated only on an IDLE accept edge. It holds its value otherwise, including while idle.
- Down-counter is sized clog2(max(HOLD_CYCLES,GAP_CYCLES)+1). It is loaded on entry to HOLD/GAP; the state exits when it reaches 1.
- Boundaries:
  - req dropped before acceptance: ignored, no grant.
  - req dropped after grant: the transfer completes unchanged.
  - Simultaneous requests: strict rotation. After requester i wins, i has lowest priority.
  - Single requester holding req: re-served every transfer.
  - rst asserted mid-transfer: every register returns to reset immediately (tx_enable drops asynchronously) and rr_ptr=0.

## Timing
- Reset values: grant=0, owner=0, busy=0, done=0, tx_bus=0, tx_enable=0, state=IDLE, rr_ptr=0, counter=0.
- Accept edge E: grant, busy and SETUP are visible in cycle E+1.
- tx_enable is high in cycles E+2 .. E+1+HOLD_CYCLES.
- GAP occupies the next GAP_CYCLES cycles. done is high in cycle E+2+HOLD_CYCLES+GAP_CYCLES.
- Back-to-back period: 2+HOLD_CYCLES+GAP_CYCLES cycles; 10 at defaults.
- All outputs are registered; no combinational path from req to any output.

## Configuration
- CDC_TX_ACK_EN defined:
  - ack_async passes through a SYNC_STAGES flop chain to give ack_s.
  - HOLD lasts at least HOLD_CYCLES and until ack_s=1.
  - GAP lasts at least GAP_CYCLES and until ack_s=0 (four-phase handshake).
  - ack_s resets to 0.
- CDC_TX_ACK_EN undefined: the ack_async port and chain are absent, and the timing is purely the fixed counts above.

## Structure
- Shared package cdc_ctrl_pkg holds:
  - state enum (IDLE, SETUP, HOLD, GAP)
  - default parameter constants
  - a clog2-based width helper
- Sub-module rr_arbiter (NUM_REQ): inputs req, ptr, enable; outputs one-hot gnt and index.
  - Purely combinational; registering is done in the controller.

## Test plan
- Reset: hold rst low 3 cycles with req=4'b1111 → all outputs 0; after release, first grant is to requester 0.
- Single transfer: req[2]=1 with data 8'hA5, defaults → grant=4'b0100 at E+1, tx_bus=8'hA5, tx_enable high exactly 4 cycles, done at E+10.
- Round-robin: req=4'b1011 held → grant order 0,1,3,0,1,3, with consecutive grants 10 cycles apart.
- Abort: rst low during HOLD's 2nd cycle → tx_enable 0 in the same cycle; busy=0; next grant comes from requester 0.
- Late drop: req[1] deasserted in SETUP → transfer still completes with done; no further grant to requester 1.
- CDC_TX_ACK_EN: ack_async raised 7 cycles after tx_enable rises and dropped 5 cycles after tx_enable falls → HOLD stretches to 7+SYNC_STAGES cycles; done follows ack_s falling.
